// File: rtl/pwm_sample_pacer_if.sv
// rtl/pwm_sample_pacer_if.sv - sample write and PWM output signals of the pacing buffer
//
// Purpose: bundles the sample-write handshake, the underflow clear and the paced
//          PWM-side outputs of pwm_sample_pacer into one connection.
// Signals:
//   i_wr             write request; a sample is taken when i_wr && o_ready
//   i_data    [DW]   sample to write
//   o_ready          buffer not full (registered)
//   i_clr_underflow  clears the sticky underflow flag
//   o_data    [DW]   sample currently presented to the PWM stage
//   o_stb            one-cycle pulse on every sample tick
//   o_fill    [AW+1] entries stored, 0..2^AW
//   o_underflow      sticky: a tick found the buffer empty
// Modports: master = sample source / PWM consumer side, slave = the pacer.
interface pwm_sample_pacer_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          i_wr;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          i_clr_underflow;
  logic [DW-1:0] o_data;
  logic          o_stb;
  logic [AW:0]   o_fill;
  logic          o_underflow;

  modport master (
    output i_wr, i_data, i_clr_underflow,
    input  o_ready, o_data, o_stb, o_fill, o_underflow
  );

  modport slave (
    input  i_wr, i_data, i_clr_underflow,
    output o_ready, o_data, o_stb, o_fill, o_underflow
  );
endinterface

// File: rtl/pwm_sample_pacer.sv
// rtl/pwm_sample_pacer.sv - FIFO that releases one audio sample per sample period to the PWM stage
//
// Purpose: accepts samples in bursts, stores them in a 2^AW-entry FIFO and hands
//          exactly one sample to the PWM stage every CLKS_PER_SAMPLE clocks,
//          strobing o_stb on every tick. Tracks fill level and latches underflow.
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-high reset; discards all stored samples
//   bus      pwm_sample_pacer_if.slave (write handshake, clear, paced outputs)
// Parameters: DW sample width, AW address width (depth 2^AW),
//             CLKS_PER_SAMPLE clocks per output sample (>= 2).
// Build option: PWMPACER_MIDSCALE_EN - when defined, o_data resets to mid-scale
//             (1<<(DW-1)) and an underflow tick loads mid-scale (silence);
//             when undefined, o_data resets to 0 and an underflow holds the last sample.
module pwm_sample_pacer #(
  parameter int DW              = 8,
  parameter int AW              = 4,
  parameter int CLKS_PER_SAMPLE = 2268
) (
  input  logic              i_clk,
  input  logic              i_reset,
  pwm_sample_pacer_if.slave bus
);

  localparam int              DEPTH      = 1 << AW;
  localparam int              CW         = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CW-1:0]   DIV_RELOAD = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [AW:0]     FILL_FULL  = (AW+1)'(DEPTH);
`ifdef PWMPACER_MIDSCALE_EN
  localparam logic [DW-1:0]   DATA_RESET = DW'(1) << (DW - 1);
`else
  localparam logic [DW-1:0]   DATA_RESET = '0;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   fill;
  logic [AW:0]   fill_next;
  logic [CW-1:0] div_count;
  logic          tick;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ready_q;
  logic          stb_q;
  logic          underflow_q;
  logic [DW-1:0] data_q;

  assign tick  = (div_count == '0);
  assign empty = (fill == '0);
  // ready_q is registered, so a slot freed by a pop only admits a write next cycle.
  assign push  = bus.i_wr && ready_q;
  // An empty tick never bypasses a same-cycle write straight to o_data.
  assign pop   = tick && !empty;

  always_comb begin
    fill_next = fill;
    case ({push, pop})
      2'b10:   fill_next = fill + 1'b1;
      2'b01:   fill_next = fill - 1'b1;
      default: fill_next = fill;
    endcase
  end

  // Sample-period divider: down-counter, tick on zero, reload on tick.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_count <= DIV_RELOAD;
    end else if (tick) begin
      div_count <= DIV_RELOAD;
    end else begin
      div_count <= div_count - 1'b1;
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wptr] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr    <= '0;
      rptr    <= '0;
      fill    <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      fill    <= fill_next;
      ready_q <= (fill_next != FILL_FULL);
    end
  end

  // Output side: strobe on every tick, even when empty, so PWM timing stays periodic.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_q      <= DATA_RESET;
      stb_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      stb_q <= tick;
      if (pop) begin
        data_q <= mem[rptr];
      end
`ifdef PWMPACER_MIDSCALE_EN
      else if (tick) begin
        data_q <= DATA_RESET;
      end
`endif
      // Setting wins over a same-cycle clear so no empty tick is ever lost.
      if (tick && empty) begin
        underflow_q <= 1'b1;
      end else if (bus.i_clr_underflow) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_data      = data_q;
  assign bus.o_stb       = stb_q;
  assign bus.o_fill      = fill;
  assign bus.o_underflow = underflow_q;

  fill_bounded: assert property (@(posedge i_clk) disable iff (i_reset) fill <= FILL_FULL);
  ready_matches_fill: assert property (@(posedge i_clk) disable iff (i_reset) ready_q == (fill != FILL_FULL));

endmodule
